ps2_command_decoder: RTL and testbench



---
 rtl/ps2_command_decoder.sv | 192 +++++++++++++++++++
 tb/tb_ps2_command_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_command_decoder.sv
// PS/2 keyboard front end.
// It receives PS/2 frames and decodes make, break and extended prefixes.
// It keeps a mask of held command keys and drives a priority one-hot command bus.
//
// Handshake: code_valid is a one-cycle strobe. It qualifies scan_code and has no backpressure.
// frame_err is a one-cycle strobe. The two strobes are never high in the same cycle.
module ps2_command_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  KEY_ATTACK     = 8'h1C,
  parameter logic [7:0]  KEY_BLOCK      = 8'h23,
  parameter logic [7:0]  KEY_SPECIAL    = 8'h1B,
  parameter logic [7:0]  KEY_START      = 8'h29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keyboard_input,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          code_valid_q, code_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [3:0]    mask_q, mask_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [3:0]    kb_q, kb_d;

  // Synchroniser chain. The extra ps2_clk stage gives the previous value used for edge detection.
  logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
  logic ps2d_s1_q, ps2d_s2_q;
  logic fall;

  // Synchronise both PS/2 pins. Reset values match the idle-high bus, so no false edge is seen after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2c_s1_q   <= 1'b1;
      ps2c_s2_q   <= 1'b1;
      ps2c_prev_q <= 1'b1;
      ps2d_s1_q   <= 1'b1;
      ps2d_s2_q   <= 1'b1;
    end else begin
      ps2c_s1_q   <= ps2_clk;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_prev_q <= ps2c_s2_q;
      ps2d_s1_q   <= ps2_data;
      ps2d_s2_q   <= ps2d_s1_q;
    end
  end

  assign fall = ps2c_prev_q & ~ps2c_s2_q;

  // State register for the frame FSM, the key mask and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      scan_code_q  <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      mask_q       <= '0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      kb_q         <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      scan_code_q  <= scan_code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
      mask_q       <= mask_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      kb_q         <= kb_d;
    end
  end

  // Next state: frame reception, timeout supervision and make/break decoding.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tmo_d        = tmo_q;
    scan_code_d  = scan_code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    mask_d       = mask_q;
    brk_d        = brk_q;
    ext_d        = ext_q;

    // The timeout counter only runs while a frame is in progress.
    // It restarts on every PS/2 edge.
    if (state_q == S_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d       = '0;
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      brk_d       = 1'b0;
      ext_d       = 1'b0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          if (!ps2d_s2_q) begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          shift_d   = {ps2d_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = ps2d_s2_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (ps2d_s2_q && ((^shift_q) ^ parity_q)) begin
            scan_code_d  = shift_q;
            code_valid_d = 1'b1;
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              // Extended codes are not mapped to any command. They only consume the pending flags.
              if (!ext_q) begin
                if (shift_q == KEY_ATTACK)  mask_d[0] = ~brk_q;
                if (shift_q == KEY_BLOCK)   mask_d[1] = ~brk_q;
                if (shift_q == KEY_SPECIAL) mask_d[2] = ~brk_q;
                if (shift_q == KEY_START)   mask_d[3] = ~brk_q;
              end
              brk_d = 1'b0;
              ext_d = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            brk_d       = 1'b0;
            ext_d       = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Priority one-hot of the held mask: attack > block > special > start.
  always_comb begin
    kb_d = 4'b0000;
    if (mask_q[0])      kb_d = 4'b0001;
    else if (mask_q[1]) kb_d = 4'b0010;
    else if (mask_q[2]) kb_d = 4'b0100;
    else if (mask_q[3]) kb_d = 4'b1000;
  end

  assign keyboard_input = kb_q;
  assign scan_code      = scan_code_q;
  assign code_valid     = code_valid_q;
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_ps2_command_decoder.sv
// Directed bench for ps2_command_decoder: vector table plus hand-written corner sequences.
module tb_ps2_command_decoder;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] keyboard_input;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  ps2_command_decoder #(.TIMEOUT_CYCLES(50)) dut (
    .clk            (clk),
    .reset          (reset),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .keyboard_input (keyboard_input),
    .scan_code      (scan_code),
    .code_valid     (code_valid),
    .frame_err      (frame_err)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling clock edge
  int       cv_cnt = 0;
  int       fe_cnt = 0;
  int       overlap = 0;
  int       cv_cyc = -10;
  int       fe_cyc = -10;
  logic [3:0] kb_at_cv = '0;
  logic [3:0] kb_after_cv = '0;
  always @(negedge clk) begin
    if (code_valid) begin
      cv_cnt   = cv_cnt + 1;
      cv_cyc   = cyc;
      kb_at_cv = keyboard_input;
    end
    if (cyc == cv_cyc + 1) kb_after_cv = keyboard_input;
    if (frame_err) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
    if (code_valid && frame_err) overlap = overlap + 1;
  end

  // Scoreboard counters
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Driver tasks: one PS/2 bit is 16 clk cycles, and the pin falls in the middle.
  int pin_fall_cyc = 0;

  task automatic ps2_fall(input logic v);
    ps2_data = v;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    pin_fall_cyc = cyc;
  endtask

  task automatic ps2_rise();
    repeat (8) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2_fall(v);
    ps2_rise();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cv_cnt = 0;
    fe_cnt = 0;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       bad_stop;
    logic [7:0] exp_cv;
    logic [7:0] exp_fe;
    logic [7:0] exp_scan;
    logic [3:0] exp_kb;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b, input logic bp, input logic bs,
                              input logic [7:0] cv, input logic [7:0] fe,
                              input logic [7:0] sc, input logic [3:0] kb);
    vec_t v;
    v.b = b; v.bad_par = bp; v.bad_stop = bs;
    v.exp_cv = cv; v.exp_fe = fe; v.exp_scan = sc; v.exp_kb = kb;
    return v;
  endfunction

  vec_t vt[$];
  bit   seen;

  initial begin
    // Table entries. The starting state is mask = attack held, no pending flags, scan_code = 1C.
    vt.push_back(mk(8'h23, 0, 0, 1, 0, 8'h23, 4'b0001)); // D make while A held
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 4'b0001));
    vt.push_back(mk(8'h1C, 0, 0, 1, 0, 8'h1C, 4'b0010)); // A release -> D shows
    vt.push_back(mk(8'h29, 1, 0, 0, 1, 8'h1C, 4'b0010)); // bad parity
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 4'b0010));
    vt.push_back(mk(8'h29, 0, 0, 1, 0, 8'h29, 4'b0010)); // release of unheld key
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 4'b0010));
    vt.push_back(mk(8'h23, 0, 0, 1, 0, 8'h23, 4'b0000));
    vt.push_back(mk(8'hE0, 0, 0, 1, 0, 8'hE0, 4'b0000));
    vt.push_back(mk(8'h1C, 0, 0, 1, 0, 8'h1C, 4'b0000)); // extended: unmapped
    vt.push_back(mk(8'h1C, 0, 0, 1, 0, 8'h1C, 4'b0001));
    vt.push_back(mk(8'h1C, 0, 0, 1, 0, 8'h1C, 4'b0001)); // typematic repeat
    vt.push_back(mk(8'hE0, 0, 0, 1, 0, 8'hE0, 4'b0001));
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 4'b0001));
    vt.push_back(mk(8'h1C, 0, 0, 1, 0, 8'h1C, 4'b0001)); // extended break ignored
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 4'b0001));
    vt.push_back(mk(8'h23, 1, 0, 0, 1, 8'hF0, 4'b0001)); // error clears break flag
    vt.push_back(mk(8'h23, 0, 0, 1, 0, 8'h23, 4'b0001)); // so this is a make: mask 0011
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 4'b0001));
    vt.push_back(mk(8'h1C, 0, 0, 1, 0, 8'h1C, 4'b0010)); // mask 0010
    vt.push_back(mk(8'h29, 0, 1, 0, 1, 8'h1C, 4'b0010)); // bad stop bit
    vt.push_back(mk(8'h29, 0, 0, 1, 0, 8'h29, 4'b0010)); // mask 1010
    vt.push_back(mk(8'h1B, 0, 0, 1, 0, 8'h1B, 4'b0010)); // mask 1110
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 4'b0010));
    vt.push_back(mk(8'h23, 0, 0, 1, 0, 8'h23, 4'b0100)); // mask 1100
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 4'b0100));
    vt.push_back(mk(8'h1B, 0, 0, 1, 0, 8'h1B, 4'b1000)); // mask 1000
    vt.push_back(mk(8'hF0, 0, 0, 1, 0, 8'hF0, 4'b1000));
    vt.push_back(mk(8'h29, 0, 0, 1, 0, 8'h29, 4'b0000));
    vt.push_back(mk(8'h55, 0, 0, 1, 0, 8'h55, 4'b0000)); // unmapped code

    // Reset
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_kb", {4'b0, keyboard_input}, 8'h00);
    check("reset_scan", scan_code, 8'h00);
    check("reset_cv", {7'b0, code_valid}, 8'h00);
    check("reset_fe", {7'b0, frame_err}, 8'h00);
    @(posedge clk); #1;

    // First A make. keyboard_input must still be 0 while code_valid is high and read 0001 one cycle later.
    clear_mon();
    send_frame(8'h1C, 0, 0);
    check("first_cv_cnt", cv_cnt[7:0], 8'd1);
    check("first_scan", scan_code, 8'h1C);
    check("kb_at_valid", {4'b0, kb_at_cv}, 8'h00);
    check("kb_after_valid", {4'b0, kb_after_cv}, 8'h01);

    // Table
    foreach (vt[i]) begin
      clear_mon();
      send_frame(vt[i].b, vt[i].bad_par, vt[i].bad_stop);
      check($sformatf("vec%0d_cv", i), cv_cnt[7:0], vt[i].exp_cv);
      check($sformatf("vec%0d_fe", i), fe_cnt[7:0], vt[i].exp_fe);
      check($sformatf("vec%0d_scan", i), scan_code, vt[i].exp_scan);
      check($sformatf("vec%0d_kb", i), {4'b0, keyboard_input}, {4'b0, vt[i].exp_kb});
    end

    // Timeout: send the start bit and 5 data bits, then let the line idle.
    clear_mon();
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (fe_cnt != 0) seen = 1'b1;
    end
    check("tmo_seen", {7'b0, seen}, 8'h01);
    check("tmo_delay_ok", {7'b0, ((fe_cyc - pin_fall_cyc) >= 50) && ((fe_cyc - pin_fall_cyc) <= 56)}, 8'h01);
    check("tmo_cv", cv_cnt[7:0], 8'd0);
    check("tmo_scan", scan_code, 8'h55);
    clear_mon();
    send_frame(8'h1B, 0, 0);
    check("post_tmo_kb", {4'b0, keyboard_input}, 8'h04);
    check("post_tmo_fe", fe_cnt[7:0], 8'd0);

    // Hold B, then reset during bit 4 of an F0 frame
    send_frame(8'h23, 0, 0);
    check("b_held_kb", {4'b0, keyboard_input}, 8'h02);
    clear_mon();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    ps2_fall(1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_kb", {4'b0, keyboard_input}, 8'h00);
    check("rst_mid_scan", scan_code, 8'h00);
    check("rst_mid_cv", {7'b0, code_valid}, 8'h00);
    check("rst_mid_fe", {7'b0, frame_err}, 8'h00);
    ps2_rise();
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    repeat (80) @(posedge clk);
    #1;
    check("rst_absorb_cv", cv_cnt[7:0], 8'd0);
    check("rst_absorb_fe", fe_cnt[7:0], 8'd0);
    check("rst_absorb_kb", {4'b0, keyboard_input}, 8'h00);
    clear_mon();
    send_frame(8'h1C, 0, 0);
    check("post_rst_kb", {4'b0, keyboard_input}, 8'h01);
    check("post_rst_scan", scan_code, 8'h1C);

    check("no_overlap", overlap[7:0], 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
